// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// Latency: combinational.
// Backpressure: none; the caller registers the result every CALC cycle.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   part,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   nxt,
    output logic                 qbit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, part[2*WIDTH-1:WIDTH]} + (part[0] ? {1'b0, opnd} : '0);
        // remainder shifted left with the next dividend bit pulled in
        rem_sh = part[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, opnd};
        qbit   = 1'b0;
        nxt    = {sum, part[WIDTH-1:1]};
        if (div_mode) begin
            qbit = (rem_sh >= {1'b0, opnd});
            nxt  = {(qbit ? WIDTH'(diff) : WIDTH'(rem_sh)), part[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one radix-2 step per clock.
// Latency: busy for WIDTH+1 cycles after launch, done pulse and new HI/LO after edge WIDTH+2.
// Backpressure: stall_o holds dependent/new instructions while busy; start while busy is dropped.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_o
);

    localparam int CW = cnt_w(WIDTH);

    state_t             state, state_nxt;
    logic               launch;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] part;
    logic [2*WIDTH-1:0] step_nxt;
    logic               step_q;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, neg_res, neg_rem, div0;

    logic               op_div, op_signed, sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               wr_ok, fix_wr;

    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign sgn_a     = op_signed & rs_val[WIDTH-1];
    assign sgn_b     = op_signed & rt_val[WIDTH-1];
    assign mag_a     = sgn_a ? -rs_val : rs_val;
    assign mag_b     = sgn_b ? -rt_val : rt_val;

    assign wr_ok   = (state == ST_IDLE) && !start;
    assign fix_wr  = (state == ST_FIX) && !flush;
    assign stall_o = busy & (mf_req | start | hi_we | lo_we);

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                state_nxt = ST_CALC;
                launch    = 1'b1;
            end
            ST_CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
            launch    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div),
        .part     (part),
        .opnd     (opnd),
        .nxt      (step_nxt),
        .qbit     (step_q)
    );

    // Magnitudes are corrected here; a zero divisor leaves rem = |dividend|,
    // so the signed remainder restores rs_val and only LO needs forcing.
    always_comb begin
        prod   = neg_res ? -part : part;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            res_hi = neg_rem ? -part[2*WIDTH-1:WIDTH] : part[2*WIDTH-1:WIDTH];
            res_lo = div0 ? '1 : (neg_res ? -part[WIDTH-1:0] : part[WIDTH-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            part    <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_nxt != ST_IDLE);
            if (launch) begin
                cnt     <= '0;
                is_div  <= op_div;
                neg_res <= sgn_a ^ sgn_b;
                neg_rem <= sgn_a;
                div0    <= op_div && (rt_val == '0);
                part    <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                opnd    <= op_div ? mag_b : mag_a;
            end else if (state == ST_CALC) begin
                part <= step_nxt | {{(2*WIDTH-1){1'b0}}, step_q};
                cnt  <= cnt + CW'(1);
            end
            if (fix_wr) begin
                hi   <= res_hi;
                lo   <= res_lo;
                done <= 1'b1;
            end else if (wr_ok) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed literal cases plus random traffic
// compared every cycle against a cycle-count/arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, start, hi_we, lo_we, mf_req, flush;
    logic [1:0]   op;
    logic [W-1:0] rs_val, rt_val, wdata;
    logic [W-1:0] hi, lo;
    logic         busy, done, stall_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .mf_req  (mf_req),
        .flush   (flush),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall_o (stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Architectural result {hi,lo} computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: return sa * sb;
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Reference model: an operation is just "result appears WIDTH+2 edges after launch".
    int          m_rem = 0;
    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem = 0; m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0;
        end else begin
            m_done = 1'b0;
            if (flush) begin
                m_rem  = 0;
                m_busy = 1'b0;
            end else if (m_rem == 0) begin
                if (start) begin
                    m_res  = ref_res(op, rs_val, rt_val);
                    m_rem  = W + 1;
                    m_busy = 1'b1;
                end else begin
                    if (hi_we) m_hi = wdata;
                    if (lo_we) m_lo = wdata;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi   = m_res[63:32];
                    m_lo   = m_res[31:0];
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sb_busy", 64'(busy), 64'(m_busy));
            chk("sb_done", 64'(done), 64'(m_done));
            chk("sb_hi", 64'(hi), 64'(m_hi));
            chk("sb_lo", 64'(lo), 64'(m_lo));
            chk("sb_stall", 64'(stall_o), 64'(m_busy & (mf_req | start | hi_we | lo_we)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; op = 2'b00; rs_val = '0; rt_val = '0;
        hi_we = 0; lo_we = 0; wdata = '0; mf_req = 0; flush = 0;
    endtask

    task automatic wait_idle(input string nm, output int bc);
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            tick();
        end
        if (bc >= 100) chk({nm, "_timeout"}, 64'(busy), 64'd0);
    endtask

    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int bc;
        op = o; rs_val = a; rt_val = b; start = 1;
        tick();
        start = 0;
        wait_idle(nm, bc);
        chk({nm, "_busy_cycles"}, 64'(bc), 64'd33);
        chk({nm, "_done"}, 64'(done), 64'd1);
        chk({nm, "_hi"}, 64'(hi), 64'(ehi));
        chk({nm, "_lo"}, 64'(lo), 64'(elo));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'(0) - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc, dc;
        idle_inputs();
        rst_n = 0;
        repeat (2) tick();
        chk_en = 1'b1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1;
        tick();

        // back-to-back: each launch lands in the previous op's done cycle
        do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        do_op("mult_neg", 2'b00, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB);
        do_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        do_op("div_by0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        do_op("div_neg_by0", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        do_op("divu_by0", 2'b11, 32'h80000001, 32'd0, 32'h80000001, 32'hFFFFFFFF);
        do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        idle_inputs();
        repeat (2) tick();

        // stall: MFxx behind a running MULT
        op = 2'b00; rs_val = 32'd5; rt_val = 32'd6; start = 1;
        tick();
        start = 0;
        repeat (9) tick();
        mf_req = 1;
        #1;
        chk("stall_busy", 64'(stall_o), 64'd1);
        wait_idle("stall", bc);
        chk("stall_idle", 64'(stall_o), 64'd0);
        chk("stall_lo", 64'(lo), 64'd30);
        mf_req = 0;
        tick();

        // flush keeps pre-existing HI/LO
        hi_we = 1; wdata = 32'hA; tick();
        hi_we = 0; lo_we = 1; wdata = 32'hB; tick();
        lo_we = 0;
        op = 2'b00; rs_val = 32'd9; rt_val = 32'd9; start = 1; tick();
        start = 0;
        repeat (4) tick();
        flush = 1; tick();
        flush = 0;
        chk("flush_busy", 64'(busy), 64'd0);
        dc = 0;
        repeat (40) begin
            if (done) dc++;
            tick();
        end
        chk("flush_no_done", 64'(dc), 64'd0);
        chk("flush_hi", 64'(hi), 64'hA);
        chk("flush_lo", 64'(lo), 64'hB);

        // reset mid-DIV
        op = 2'b10; rs_val = 32'd100; rt_val = 32'd7; start = 1; tick();
        start = 0;
        repeat (10) tick();
        rst_n = 0; tick();
        rst_n = 1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        tick();

        // MTHI alone, then MTHI colliding with a start
        hi_we = 1; wdata = 32'h1234; tick();
        hi_we = 0;
        chk("mthi", 64'(hi), 64'h1234);
        hi_we = 1; wdata = 32'h5555; op = 2'b01; rs_val = 32'd2; rt_val = 32'd3; start = 1;
        tick();
        hi_we = 0; start = 0;
        chk("mthi_vs_start_hi", 64'(hi), 64'h1234);
        chk("mthi_vs_start_busy", 64'(busy), 64'd1);
        wait_idle("mthi_op", bc);
        chk("mthi_op_lo", 64'(lo), 64'd6);
        chk("mthi_op_hi", 64'(hi), 64'd0);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            op     = 2'($urandom_range(0, 3));
            rs_val = rnd_val();
            rt_val = rnd_val();
            flush  = ($urandom_range(0, 59) == 0);
            hi_we  = !flush && ($urandom_range(0, 5) == 0);
            lo_we  = !flush && ($urandom_range(0, 5) == 0);
            wdata  = $urandom;
            mf_req = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
